// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port burst memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W     = 7;
   localparam int DATA_W     = 32;
   localparam int LEN_W      = 4;
   localparam int WORD_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      BEAT  = 2'd2,
      DONE  = 2'd3
   } state_e;

   function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

   // Word-stride increment; the natural ADDR_W overflow gives the 0x7C -> 0x00 wrap.
   function automatic logic [ADDR_W-1:0] next_word(input logic [ADDR_W-1:0] a);
      return a + ADDR_W'(WORD_BYTES);
   endfunction

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational winner select between two requesters; ptr names the port that wins a tie.
module mem_arb_sel (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic       valid,
   output logic       win
);

   always_comb begin
      valid = |req;
      win   = 1'b0;
      if (req == 2'b11) win = ptr;
      else if (req[1])  win = 1'b1;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master burst arbiter/sequencer for a negedge-clocked 128-byte word memory.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module mem_arbiter
   import mem_arb_pkg::*;
(
   input  logic              CLK,
   input  logic              ARESETn,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [LEN_W-1:0]  m0_len,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_wready,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_done,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [LEN_W-1:0]  m1_len,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_wready,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_done,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_writefinish,
   output logic              wr_err
);

   state_e              state_q, state_d;
   logic                owner_q, owner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;

   logic [1:0]          gnt_q, gnt_d;
   logic [1:0]          wready_q, wready_d;
   logic [1:0]          rvalid_q, rvalid_d;
   logic [1:0]          done_q, done_d;
   logic [DATA_W-1:0]   rdata_q [2];
   logic [DATA_W-1:0]   rdata_d [2];
   logic                mem_cs_q, mem_cs_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                wr_err_q, wr_err_d;

   logic                sel_valid, sel_win, sel_ptr;

   mem_arb_sel u_sel (
      .req   ({m1_req, m0_req}),
      .ptr   (sel_ptr),
      .valid (sel_valid),
      .win   (sel_win)
   );

`ifdef MEM_ARB_RR_EN
   logic ptr_q, ptr_d;

   // The port just granted loses the next tie.
   always_comb begin
      ptr_d = ptr_q;
      if (state_q == IDLE && sel_valid) ptr_d = ~sel_win;
   end

   always_ff @(posedge CLK or negedge ARESETn) begin
      if (!ARESETn) ptr_q <= 1'b0;
      else          ptr_q <= ptr_d;
   end

   assign sel_ptr = ptr_q;
`else
   assign sel_ptr = 1'b0;
`endif

   // NOTE: state and registered outputs update with <= so every flop sees pre-edge values.
   always_ff @(posedge CLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         base_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         wready_q    <= '0;
         rvalid_q    <= '0;
         done_q      <= '0;
         rdata_q[0]  <= '0;
         rdata_q[1]  <= '0;
         mem_cs_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         wr_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         base_q      <= base_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         wready_q    <= wready_d;
         rvalid_q    <= rvalid_d;
         done_q      <= done_d;
         rdata_q[0]  <= rdata_d[0];
         rdata_q[1]  <= rdata_d[1];
         mem_cs_q    <= mem_cs_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         wr_err_q    <= wr_err_d;
      end
   end

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      we_d    = we_q;
      base_d  = base_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (sel_valid) begin
               owner_d = sel_win;
               we_d    = sel_win ? m1_we : m0_we;
               base_d  = align_word(sel_win ? m1_addr : m0_addr);
               len_d   = sel_win ? m1_len : m0_len;
               cnt_d   = '0;
               state_d = GRANT;
            end
         end
         GRANT: state_d = BEAT;
         BEAT: begin
            if (cnt_q == len_q) state_d = DONE;
            else                cnt_d   = cnt_q + LEN_W'(1);
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are computed for the cycle being entered, then registered.
   always_comb begin
      gnt_d       = '0;
      wready_d    = '0;
      rvalid_d    = '0;
      done_d      = '0;
      rdata_d     = rdata_q;
      mem_cs_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      wr_err_d    = wr_err_q;
      case (state_d)
         GRANT: begin
            gnt_d[owner_d]    = 1'b1;
            wready_d[owner_d] = we_d;
         end
         BEAT: begin
            gnt_d[owner_q]    = 1'b1;
            mem_cs_d          = 1'b1;
            mem_we_d          = we_q;
            mem_addr_d        = (state_q == GRANT) ? base_q : next_word(mem_addr_q);
            wready_d[owner_q] = we_q && (cnt_d < len_q);
            if (we_q) mem_wdata_d = owner_q ? m1_wdata : m0_wdata;
         end
         DONE: begin
            gnt_d[owner_q]  = 1'b1;
            done_d[owner_q] = 1'b1;
         end
         default: ;
      endcase
      // Read data appears one edge after the beat that addressed it.
      if (mem_cs_q && !mem_we_q) begin
         rvalid_d[owner_q] = 1'b1;
         rdata_d[owner_q]  = mem_rdata;
      end
      if (state_q == DONE && we_q && !mem_writefinish) wr_err_d = 1'b1;
   end

   assign m0_gnt    = gnt_q[0];
   assign m1_gnt    = gnt_q[1];
   assign m0_wready = wready_q[0];
   assign m1_wready = wready_q[1];
   assign m0_rvalid = rvalid_q[0];
   assign m1_rvalid = rvalid_q[1];
   assign m0_done   = done_q[0];
   assign m1_done   = done_q[1];
   assign m0_rdata  = rdata_q[0];
   assign m1_rdata  = rdata_q[1];
   assign mem_cs    = mem_cs_q;
   assign mem_we    = mem_we_q;
   assign mem_waddr = mem_addr_q;
   assign mem_raddr = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a negedge byte-memory model (bytes 0..37 preloaded with i).
module tb_mem_arbiter;

   typedef logic [31:0] word_arr_t [16];
   typedef logic [6:0]  addr_arr_t [16];

   logic        CLK, ARESETn;
   logic [1:0]  req, we_i;
   logic [6:0]  addr_i  [2];
   logic [3:0]  len_i   [2];
   logic [31:0] wdata_i [2];
   wire  [1:0]  gnt, wready, rvalid, done;
   wire  [31:0] rdata [2];
   wire         mem_cs, mem_we, wr_err;
   wire  [6:0]  mem_waddr, mem_raddr;
   wire  [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_writefinish;

   logic [7:0]  ram [128];
   bit          wf_force_low;
   bit          log_en;
   int          grant_log [$];
   logic [1:0]  gnt_prev;
   int          checks, errors;

   mem_arbiter dut (
      .CLK(CLK), .ARESETn(ARESETn),
      .m0_req(req[0]), .m0_we(we_i[0]), .m0_addr(addr_i[0]), .m0_len(len_i[0]), .m0_wdata(wdata_i[0]),
      .m0_gnt(gnt[0]), .m0_wready(wready[0]), .m0_rvalid(rvalid[0]), .m0_rdata(rdata[0]), .m0_done(done[0]),
      .m1_req(req[1]), .m1_we(we_i[1]), .m1_addr(addr_i[1]), .m1_len(len_i[1]), .m1_wdata(wdata_i[1]),
      .m1_gnt(gnt[1]), .m1_wready(wready[1]), .m1_rvalid(rvalid[1]), .m1_rdata(rdata[1]), .m1_done(done[1]),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_writefinish(mem_writefinish),
      .wr_err(wr_err)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Memory model: acts on the falling edge; writefinish holds until the next read beat.
   always @(negedge CLK) begin
      if (mem_cs) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++) ram[int'(mem_waddr) + b] = mem_wdata[8*b +: 8];
            mem_writefinish = !wf_force_low;
         end else begin
            mem_rdata = {ram[int'(mem_raddr) + 3], ram[int'(mem_raddr) + 2],
                         ram[int'(mem_raddr) + 1], ram[int'(mem_raddr)]};
            mem_writefinish = 1'b0;
         end
      end
   end

   always @(negedge CLK) begin
      if (log_en)
         for (int p = 0; p < 2; p++)
            if (gnt[p] && !gnt_prev[p]) grant_log.push_back(p);
      gnt_prev = gnt;
   end

   // Runs one burst as requester p; cycle 0 is the first negedge that sees gnt.
   task automatic do_burst(input int p, input bit w, input logic [6:0] a, input logic [3:0] l,
                           input word_arr_t wd, output word_arr_t rd, output int rd_n,
                           output addr_arr_t ad, output int ad_n, output int done_cyc,
                           output int done_cnt);
      int cyc, idx;
      bit saw_wr, fin, seen_done;
      cyc = -1; idx = 0; fin = 0;
      rd_n = 0; ad_n = 0; done_cyc = -1; done_cnt = 0;
      rd = '{default: '0};
      ad = '{default: '0};
      req[p] = 1'b1; we_i[p] = w; addr_i[p] = a; len_i[p] = l; wdata_i[p] = wd[0];
      for (int t = 0; t < 80 && !fin; t++) begin
         @(negedge CLK);
         if (cyc >= 0) cyc++;
         else if (gnt[p]) cyc = 0;
         saw_wr = wready[p];
         seen_done = done[p];
         if (rvalid[p] && rd_n < 16) begin rd[rd_n] = rdata[p]; rd_n++; end
         if (gnt[p] && mem_cs && ad_n < 16) begin ad[ad_n] = mem_raddr; ad_n++; end
         if (seen_done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
         @(posedge CLK);
         #1;
         if (saw_wr && idx < 15) begin idx++; wdata_i[p] = wd[idx]; end
         if (seen_done) begin req[p] = 1'b0; fin = 1; end
      end
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL burst_timeout port %0d addr %h: no done within budget", p, a);
         req[p] = 1'b0;
      end
      @(negedge CLK);
      if (done[p]) done_cnt++;
   endtask

   task automatic test_reset();
      ARESETn = 1'b0;
      #1;
      checks++;
      if ({gnt, wready, rvalid, done, mem_cs, mem_we, wr_err} !== 19'd0) begin
         errors++;
         $display("FAIL reset_ctrl got %b required 0", {gnt, wready, rvalid, done, mem_cs, mem_we, wr_err});
      end
      checks++;
      if ({mem_waddr, mem_raddr, mem_wdata, rdata[0], rdata[1]} !== 110'd0) begin
         errors++;
         $display("FAIL reset_data got %h required 0", {mem_waddr, mem_raddr, mem_wdata, rdata[0], rdata[1]});
      end
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      ARESETn = 1'b1;
   endtask

   task automatic test_read_burst();
      word_arr_t wd, rd; addr_arr_t ad; int rd_n, ad_n, dc, dn;
      wd = '{default: '0};
      do_burst(0, 1'b0, 7'h04, 4'd1, wd, rd, rd_n, ad, ad_n, dc, dn);
      checks++;
      if (rd_n !== 2 || rd[0] !== 32'h07060504 || rd[1] !== 32'h0B0A0908) begin
         errors++;
         $display("FAIL read_burst_data got n=%0d %h %h required n=2 07060504 0b0a0908", rd_n, rd[0], rd[1]);
      end
      checks++;
      if (dc !== 3 || dn !== 1) begin
         errors++;
         $display("FAIL read_burst_done got cycle %0d count %0d required cycle 3 count 1", dc, dn);
      end
   endtask

   task automatic test_write_then_read();
      word_arr_t wd, rd; addr_arr_t ad; int rd_n, ad_n, dc, dn;
      wd = '{default: '0};
      wd[0] = 32'hDEADBEEF;
      do_burst(1, 1'b1, 7'h40, 4'd0, wd, rd, rd_n, ad, ad_n, dc, dn);
      checks++;
      if ({ram[8'h43], ram[8'h42], ram[8'h41], ram[8'h40]} !== 32'hDEADBEEF || rd_n !== 0) begin
         errors++;
         $display("FAIL write_mem got %h rvalids %0d required deadbeef rvalids 0",
                  {ram[8'h43], ram[8'h42], ram[8'h41], ram[8'h40]}, rd_n);
      end
      checks++;
      if (dc !== 2) begin
         errors++;
         $display("FAIL write_done_cycle got %0d required 2", dc);
      end
      do_burst(0, 1'b0, 7'h40, 4'd0, wd, rd, rd_n, ad, ad_n, dc, dn);
      checks++;
      if (rd[0] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL readback got %h required deadbeef", rd[0]);
      end
      checks++;
      if (wr_err !== 1'b0) begin
         errors++;
         $display("FAIL wr_err_clean got %b required 0", wr_err);
      end
   endtask

   task automatic test_arbitration();
      word_arr_t wd, rd0, rd1; addr_arr_t ad0, ad1;
      int n0, n1, a0, a1, dc0, dc1, dn0, dn1;
      int exp_order [3];
`ifdef MEM_ARB_RR_EN
      exp_order = '{0, 1, 0};
`else
      exp_order = '{0, 0, 1};
`endif
      wd = '{default: '0};
      grant_log.delete();
      log_en = 1'b1;
      fork
         begin
            do_burst(0, 1'b0, 7'h00, 4'd0, wd, rd0, n0, ad0, a0, dc0, dn0);
            do_burst(0, 1'b0, 7'h08, 4'd0, wd, rd0, n0, ad0, a0, dc0, dn0);
         end
         do_burst(1, 1'b0, 7'h10, 4'd0, wd, rd1, n1, ad1, a1, dc1, dn1);
      join
      log_en = 1'b0;
      checks++;
      if (grant_log.size() !== 3) begin
         errors++;
         $display("FAIL arb_count got %0d grants required 3", grant_log.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (grant_log[i] !== exp_order[i]) begin
               errors++;
               $display("FAIL arb_order[%0d] got m%0d required m%0d", i, grant_log[i], exp_order[i]);
            end
         end
      end
      checks++;
      if (rd1[0] !== 32'h13121110) begin
         errors++;
         $display("FAIL arb_m1_data got %h required 13121110", rd1[0]);
      end
   endtask

   task automatic test_wrap();
      word_arr_t wd, rd; addr_arr_t ad; int rd_n, ad_n, dc, dn;
      wd = '{default: '0};
      do_burst(0, 1'b0, 7'h7C, 4'd1, wd, rd, rd_n, ad, ad_n, dc, dn);
      checks++;
      if (ad_n !== 2 || ad[0] !== 7'h7C || ad[1] !== 7'h00) begin
         errors++;
         $display("FAIL wrap_addr got n=%0d %h %h required n=2 7c 00", ad_n, ad[0], ad[1]);
      end
      checks++;
      if (rd[1] !== 32'h03020100) begin
         errors++;
         $display("FAIL wrap_data got %h required 03020100", rd[1]);
      end
   endtask

   task automatic test_unaligned();
      word_arr_t wd, rd; addr_arr_t ad; int rd_n, ad_n, dc, dn;
      wd = '{default: '0};
      do_burst(0, 1'b0, 7'h05, 4'd0, wd, rd, rd_n, ad, ad_n, dc, dn);
      checks++;
      if (ad[0] !== 7'h04 || rd[0] !== 32'h07060504) begin
         errors++;
         $display("FAIL unaligned got addr %h data %h required 04 07060504", ad[0], rd[0]);
      end
   endtask

   task automatic test_wr_err();
      word_arr_t wd, rd; addr_arr_t ad; int rd_n, ad_n, dc, dn;
      wd = '{default: '0};
      wd[0] = 32'hCAFEF00D;
      wf_force_low = 1'b1;
      do_burst(0, 1'b1, 7'h60, 4'd0, wd, rd, rd_n, ad, ad_n, dc, dn);
      wf_force_low = 1'b0;
      checks++;
      if (wr_err !== 1'b1) begin
         errors++;
         $display("FAIL wr_err_set got %b required 1", wr_err);
      end
   endtask

   task automatic test_reset_mid_burst();
      word_arr_t wd, rd; addr_arr_t ad; int rd_n, ad_n, dc, dn;
      logic [63:0] tail;
      bit got;
      got = 0;
      req[1] = 1'b1; we_i[1] = 1'b1; addr_i[1] = 7'h20; len_i[1] = 4'd3; wdata_i[1] = 32'h11223344;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge CLK);
         got = gnt[1];
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL rst_burst_grant got no gnt required gnt within 20 cycles");
      end
      @(posedge CLK); #1 wdata_i[1] = 32'h55667788;
      @(posedge CLK); #1 wdata_i[1] = 32'h99AABBCC;
      @(negedge CLK); #1 ARESETn = 1'b0;
      #1;
      checks++;
      if ({gnt, wready, rvalid, done, mem_cs, mem_we, wr_err} !== 19'd0 ||
          {mem_waddr, mem_raddr, mem_wdata, rdata[0], rdata[1]} !== 110'd0) begin
         errors++;
         $display("FAIL rst_mid_outputs got ctrl %b data %h required all 0",
                  {gnt, wready, rvalid, done, mem_cs, mem_we, wr_err},
                  {mem_waddr, mem_raddr, mem_wdata, rdata[0], rdata[1]});
      end
      req[1] = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      ARESETn = 1'b1;
      checks++;
      if ({ram[8'h23], ram[8'h22], ram[8'h21], ram[8'h20]} !== 32'h11223344 ||
          {ram[8'h27], ram[8'h26], ram[8'h25], ram[8'h24]} !== 32'h55667788) begin
         errors++;
         $display("FAIL rst_mid_written got %h %h required 11223344 55667788",
                  {ram[8'h23], ram[8'h22], ram[8'h21], ram[8'h20]},
                  {ram[8'h27], ram[8'h26], ram[8'h25], ram[8'h24]});
      end
      for (int i = 0; i < 8; i++) tail[8*i +: 8] = ram[8'h28 + i];
      checks++;
      if (tail !== 64'd0) begin
         errors++;
         $display("FAIL rst_mid_untouched got %h required 0", tail);
      end
      wd = '{default: '0};
      do_burst(0, 1'b0, 7'h20, 4'd1, wd, rd, rd_n, ad, ad_n, dc, dn);
      checks++;
      if (rd[0] !== 32'h11223344 || rd[1] !== 32'h55667788 || dc !== 3) begin
         errors++;
         $display("FAIL rst_recover got %h %h done %0d required 11223344 55667788 done 3", rd[0], rd[1], dc);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; errors = 0;
      req = '0; we_i = '0;
      addr_i = '{default: '0}; len_i = '{default: '0}; wdata_i = '{default: '0};
      mem_rdata = '0; mem_writefinish = 1'b0;
      wf_force_low = 1'b0; log_en = 1'b0; gnt_prev = '0;
      for (int i = 0; i < 128; i++) ram[i] = (i <= 37) ? 8'(i) : 8'h00;
      test_reset();
      test_read_burst();
      test_write_then_read();
      test_arbitration();
      test_wrap();
      test_unaligned();
      test_wr_err();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
